// File: rtl/ultrasonic_ranger.sv
// HC-SR04 measurement engine: trigger generation, echo timing in microseconds, Avalon-MM slave.
// Optional interrupt support is compiled in with ULTRASONIC_IRQ_EN.
module ultrasonic_ranger #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned US_DIV         = 50,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_US     = 38000,
  parameter int unsigned HOLDOFF_CYCLES = 3000000,
  parameter int unsigned WIDTH          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  ctrl,
  input  logic        echo,
  output logic        trig,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StDone,
    StHoldoff
  } state_e;

  localparam logic [WIDTH-1:0] TimeoutLim = WIDTH'(TIMEOUT_US);

  state_e           state_q, state_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [31:0]      pre_q, pre_d;
  logic [WIDTH-1:0] us_q, us_d;
  logic             to_q, to_d;

  logic             echo_meta_q, echo_s_q;
  logic [1:0]       ctrl_q;
  logic             trig_q;

  logic [WIDTH-1:0] result_q;
  logic             valid_q, timeout_q;
  logic [15:0]      count_q;

  logic             go, tick, status_wr, busy;
  logic [31:0]      pre_step;
  logic [WIDTH-1:0] us_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      ctrl_q      <= 2'b00;
    end else begin
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      ctrl_q      <= ctrl;
    end
  end

  assign go        = (ctrl[0] & ~ctrl_q[0]) | ctrl[1];
  assign tick      = (pre_q == US_DIV - 1);
  assign pre_step  = tick ? 32'd0 : pre_q + 32'd1;
  // The microsecond count saturates rather than wrapping.
  assign us_step   = (tick && us_q != '1) ? us_q + WIDTH'(1) : us_q;
  assign busy      = (state_q != StIdle);
  assign status_wr = chipselect & ~write_n & (address == 2'd1);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    pre_d   = pre_q;
    us_d    = us_q;
    to_d    = to_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StTrig;
          cyc_d   = 32'd0;
          pre_d   = 32'd0;
          us_d    = '0;
          to_d    = 1'b0;
        end
      end
      StTrig: begin
        if (cyc_q == TRIG_CYCLES - 1) begin
          state_d = StWaitRise;
          cyc_d   = 32'd0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      StWaitRise: begin
        if (echo_s_q) begin
          state_d = StMeasure;
          pre_d   = 32'd0;
          us_d    = '0;
        end else if (us_q >= TimeoutLim) begin
          state_d = StDone;
          to_d    = 1'b1;
        end else begin
          pre_d = pre_step;
          us_d  = us_step;
        end
      end
      StMeasure: begin
        // The falling-edge clock still counts, so a full echo of N clocks yields N/US_DIV.
        if (!echo_s_q) begin
          state_d = StDone;
          pre_d   = pre_step;
          us_d    = us_step;
        end else if (us_q >= TimeoutLim) begin
          state_d = StDone;
          to_d    = 1'b1;
        end else begin
          pre_d = pre_step;
          us_d  = us_step;
        end
      end
      StDone: begin
        state_d = StHoldoff;
        cyc_d   = 32'd0;
      end
      StHoldoff: begin
        if (cyc_q == HOLDOFF_CYCLES - 1) begin
          state_d = StIdle;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cyc_q   <= 32'd0;
      pre_q   <= 32'd0;
      us_q    <= '0;
      to_q    <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      pre_q   <= pre_d;
      us_q    <= us_d;
      to_q    <= to_d;
      trig_q  <= (state_q == StTrig);
    end
  end

  assign trig = trig_q;

  // Completion beats a concurrent STATUS write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= 16'd0;
    end else if (state_q == StDone) begin
      count_q <= count_q + 16'd1;
      if (to_q) begin
        result_q  <= '1;
        timeout_q <= 1'b1;
        valid_q   <= 1'b0;
      end else begin
        result_q  <= us_q;
        timeout_q <= 1'b0;
        valid_q   <= 1'b1;
      end
    end else if (status_wr) begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end
  end

`ifdef ULTRASONIC_IRQ_EN
  logic pend_q, mask_q;
  logic mask_wr;
  logic unused_bits;

  assign mask_wr     = chipselect & ~write_n & (address == 2'd2);
  assign unused_bits = ^{writedata[31:1], 32'(CLK_HZ)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      mask_q <= 1'b0;
    end else begin
      if (state_q == StDone) begin
        pend_q <= 1'b1;
      end else if (status_wr) begin
        pend_q <= 1'b0;
      end
      if (mask_wr) begin
        mask_q <= writedata[0];
      end
    end
  end

  assign irq = pend_q & mask_q;
`else
  logic unused_bits;

  assign unused_bits = ^{writedata, 32'(CLK_HZ)};
  assign irq         = 1'b0;
`endif

  always_comb begin
    readdata = 32'd0;
    unique case (address)
      2'd0: readdata = 32'(result_q);
      2'd1: readdata = {29'd0, busy, timeout_q, valid_q};
`ifdef ULTRASONIC_IRQ_EN
      2'd2: readdata = {31'd0, mask_q};
`else
      2'd2: readdata = 32'd0;
`endif
      2'd3: readdata = 32'(count_q);
      default: readdata = 32'd0;
    endcase
  end

endmodule
